// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR coefficient controller slice.
package fir_pkg;

   localparam int unsigned TAPS  = 8;
   localparam int unsigned NSETS = 9;
   localparam int unsigned DW    = 13;

   typedef logic signed [DW-1:0] coef_t;

   typedef enum logic [1:0] {IDLE, SWAP, FLUSH} state_t;

   // Set-major flattening: tap 0 of set 0 sits in the LSBs.
   function automatic int unsigned flat_idx(input int unsigned set,
                                            input int unsigned tap,
                                            input int unsigned ntaps);
      return set * ntaps + tap;
   endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient storage: single write port into shadow,
// one-cycle full shadow->active copy on strobe.
module fir_coeff_bank import fir_pkg::*; #(
   parameter int unsigned TAPS  = fir_pkg::TAPS,
   parameter int unsigned NSETS = fir_pkg::NSETS,
   parameter int unsigned DW    = fir_pkg::DW
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wr_en,
   input  logic [3:0]                      wr_set,
   input  logic [3:0]                      wr_idx,
   input  logic [DW-1:0]                   wr_data,
   input  logic                            copy,
   output logic [NSETS*(TAPS+1)*DW-1:0]    h_act
);

   localparam int unsigned NC = NSETS * (TAPS + 1);
   localparam int unsigned AW = (NC > 1) ? $clog2(NC) : 1;

   logic [DW-1:0] shadow_q [NC];
   logic [DW-1:0] shadow_d [NC];
   logic [DW-1:0] active_q [NC];
   logic [DW-1:0] active_d [NC];
   logic [AW-1:0] wr_ptr;

   assign wr_ptr = AW'(flat_idx(32'(wr_set), 32'(wr_idx), TAPS + 1));

   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (wr_en) shadow_d[wr_ptr] = wr_data;
      if (copy)  active_d = shadow_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NC; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   always_comb begin
      h_act = '0;
      for (int unsigned i = 0; i < NC; i++) h_act[i*DW +: DW] = active_q[i];
   end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Coefficient config/sequencing controller: shadow writes, commit-triggered
// swap, optional zero flush of the FIR delay line, 1-cycle sample register.
module fir_coeff_ctrl import fir_pkg::*; #(
   parameter int unsigned TAPS     = fir_pkg::TAPS,
   parameter int unsigned NSETS    = fir_pkg::NSETS,
   parameter int unsigned DW       = fir_pkg::DW,
   parameter bit          FLUSH_EN = 1'b1
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            CFG_VALID,
   output logic                            CFG_READY,
   input  logic                            CFG_COMMIT,
   input  logic [3:0]                      CFG_SET,
   input  logic [3:0]                      CFG_IDX,
   input  logic [DW-1:0]                   CFG_DATA,
   output logic                            CFG_ERR,
   input  logic                            S_VIN,
   input  logic [DW-1:0]                   S_DIN,
   output logic                            S_READY,
   output logic                            F_VIN,
   output logic [DW-1:0]                   F_DIN,
   output logic [NSETS*(TAPS+1)*DW-1:0]    H_ACT,
   output logic                            BUSY
);

   localparam int unsigned CW = $clog2(TAPS + 2);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          f_vin_q, f_vin_d;
   logic [DW-1:0] f_din_q, f_din_d;
   logic          cfg_err_q, cfg_err_d;

   logic idle, cfg_acc, in_range, wr_ok, s_acc, copy;

   assign idle      = (state_q == IDLE);
   assign CFG_READY = idle;
   assign S_READY   = idle;
   assign BUSY      = !idle;

   assign cfg_acc  = CFG_VALID & idle;
   assign in_range = (32'(CFG_SET) < NSETS) && (32'(CFG_IDX) <= TAPS);
   assign wr_ok    = cfg_acc & !CFG_COMMIT & in_range;
   assign s_acc    = S_VIN & idle;
   assign copy     = (state_q == SWAP);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      f_vin_d   = s_acc;
      f_din_d   = s_acc ? S_DIN : f_din_q;
      cfg_err_d = cfg_acc & !CFG_COMMIT & !in_range;
      unique case (state_q)
         IDLE: if (cfg_acc && CFG_COMMIT) state_d = SWAP;
         SWAP: begin
            cnt_d = '0;
            // The SWAP cycle already emits the first flush zero.
            if (FLUSH_EN) begin
               state_d = FLUSH;
               f_vin_d = 1'b1;
               f_din_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         FLUSH: begin
            if (cnt_q == CW'(TAPS)) begin
               state_d = IDLE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               f_vin_d = 1'b1;
               f_din_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         f_vin_q   <= 1'b0;
         f_din_q   <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         f_vin_q   <= f_vin_d;
         f_din_q   <= f_din_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign F_VIN   = f_vin_q;
   assign F_DIN   = f_din_q;
   assign CFG_ERR = cfg_err_q;

   fir_coeff_bank #(
      .TAPS  (TAPS),
      .NSETS (NSETS),
      .DW    (DW)
   ) u_bank (
      .clk     (CLK),
      .rst     (RST),
      .wr_en   (wr_ok),
      .wr_set  (CFG_SET),
      .wr_idx  (CFG_IDX),
      .wr_data (CFG_DATA),
      .copy    (copy),
      .h_act   (H_ACT)
   );

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Bench for fir_coeff_ctrl: directed timing cases plus randomized traffic
// against an abstract coefficient/sample model.
module tb_fir_coeff_ctrl;
   import fir_pkg::*;

   localparam int unsigned T  = TAPS;
   localparam int unsigned N  = NSETS;
   localparam int unsigned W  = DW;
   localparam int unsigned HW = N * (T + 1) * W;
   localparam logic [W-1:0] NEG1234 = W'(-1234);

   logic          CLK = 1'b0;
   logic          RST;
   logic          cfg_valid, cfg_commit;
   logic [3:0]    cfg_set, cfg_idx;
   logic [W-1:0]  cfg_data;
   logic          s_vin;
   logic [W-1:0]  s_din;

   logic          a_crdy, a_err, a_srdy, a_fvin, a_busy;
   logic [W-1:0]  a_fdin;
   logic [HW-1:0] a_hact;
   logic          b_crdy, b_err, b_srdy, b_fvin, b_busy;
   logic [W-1:0]  b_fdin;
   logic [HW-1:0] b_hact;

   always #5 CLK = ~CLK;

   fir_coeff_ctrl #(.FLUSH_EN(1'b1)) dut (
      .CLK(CLK), .RST(RST),
      .CFG_VALID(cfg_valid), .CFG_READY(a_crdy), .CFG_COMMIT(cfg_commit),
      .CFG_SET(cfg_set), .CFG_IDX(cfg_idx), .CFG_DATA(cfg_data), .CFG_ERR(a_err),
      .S_VIN(s_vin), .S_DIN(s_din), .S_READY(a_srdy),
      .F_VIN(a_fvin), .F_DIN(a_fdin), .H_ACT(a_hact), .BUSY(a_busy)
   );

   fir_coeff_ctrl #(.FLUSH_EN(1'b0)) dut_nf (
      .CLK(CLK), .RST(RST),
      .CFG_VALID(cfg_valid), .CFG_READY(b_crdy), .CFG_COMMIT(cfg_commit),
      .CFG_SET(cfg_set), .CFG_IDX(cfg_idx), .CFG_DATA(cfg_data), .CFG_ERR(b_err),
      .S_VIN(s_vin), .S_DIN(s_din), .S_READY(b_srdy),
      .F_VIN(b_fvin), .F_DIN(b_fdin), .H_ACT(b_hact), .BUSY(b_busy)
   );

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic logic [W-1:0] coef(input logic [HW-1:0] h, input int unsigned s,
                                         input int unsigned t);
      return h[(s*(T+1)+t)*W +: W];
   endfunction

   // Abstract model state
   logic [W-1:0] msh  [N][T+1];
   logic [W-1:0] mact [N][T+1];
   int           mbusy;
   bit           pend;
   logic         e_fvin, e_err;
   logic [W-1:0] e_fdin;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [HW-1:0] m35;
      bit            rdy_prev, rdy;
      bit            cfg_hold, s_hold;
      int            n, beats, cyc;

      m35 = '0;
      m35[(3*(T+1)+5)*W +: W] = '1;

      RST = 1'b1; cfg_valid = 0; cfg_commit = 0; cfg_set = 0; cfg_idx = 0;
      cfg_data = '0; s_vin = 0; s_din = '0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      check("rst_hact", 64'(|a_hact), 64'(0));
      check("rst_fvin", 64'(a_fvin), 64'(0));
      check("rst_fdin", 64'(a_fdin), 64'(0));
      check("rst_err",  64'(a_err),  64'(0));
      check("rst_srdy", 64'(a_srdy), 64'(1));
      check("rst_crdy", 64'(a_crdy), 64'(1));
      check("rst_busy", 64'(a_busy), 64'(0));

      // Shadow write only: active bank must stay untouched
      cfg_valid = 1; cfg_set = 4'd3; cfg_idx = 4'd5; cfg_data = NEG1234;
      @(negedge CLK);
      cfg_valid = 0;
      check("wr_err", 64'(a_err), 64'(0));
      repeat (3) @(negedge CLK);
      check("wr_no_act", 64'(|a_hact), 64'(0));

      // Commit with continuous sample stream
      check("pre_commit_rdy", 64'(a_srdy), 64'(1));
      cfg_valid = 1; cfg_commit = 1; s_vin = 1; s_din = W'(100); rdy_prev = 1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge CLK);
         if (k == 1) begin cfg_valid = 0; cfg_commit = 0; end
         check($sformatf("st_srdy_%0d", k), 64'(a_srdy), 64'(k >= 11));
         check($sformatf("st_busy_%0d", k), 64'(a_busy), 64'(k <= 10));
         check($sformatf("st_fvin_%0d", k), 64'(a_fvin), 64'((k <= 10) || (k == 12)));
         check($sformatf("st_fdin_%0d", k), 64'(a_fdin),
               64'((k == 1) ? 100 : ((k == 12) ? 101 : 0)));
         if (k == 1) begin
            check("st_old_hact", 64'(|a_hact), 64'(0));
            check("nf_srdy_1", 64'(b_srdy), 64'(0));
            check("nf_fvin_1", 64'(b_fvin), 64'(1));
            check("nf_fdin_1", 64'(b_fdin), 64'(100));
         end
         if (k == 2) begin
            check("st_new_h35", 64'(coef(a_hact, 3, 5)), 64'(NEG1234));
            check("st_new_rest", 64'(|(a_hact & ~m35)), 64'(0));
            check("nf_srdy_2", 64'(b_srdy), 64'(1));
            check("nf_fvin_2", 64'(b_fvin), 64'(0));
            check("nf_h35", 64'(coef(b_hact, 3, 5)), 64'(NEG1234));
         end
         if (k == 3) begin
            check("nf_fvin_3", 64'(b_fvin), 64'(1));
            check("nf_fdin_3", 64'(b_fdin), 64'(101));
         end
         if (rdy_prev) s_din = s_din + 1'b1;
         rdy_prev = a_srdy;
      end
      s_vin = 0;
      repeat (2) @(negedge CLK);

      // Out-of-range writes
      cfg_valid = 1; cfg_commit = 0; cfg_set = 4'd9; cfg_idx = 4'd0; cfg_data = W'(55);
      @(negedge CLK);
      check("err_set9", 64'(a_err), 64'(1));
      check("err_set9_nf", 64'(b_err), 64'(1));
      cfg_set = 4'd0; cfg_idx = 4'd9;
      @(negedge CLK);
      cfg_valid = 0;
      check("err_idx9", 64'(a_err), 64'(1));
      @(negedge CLK);
      check("err_pulse_end", 64'(a_err), 64'(0));
      cfg_valid = 1; cfg_commit = 1;
      @(negedge CLK);
      cfg_valid = 0; cfg_commit = 0;
      n = 0;
      while (!a_srdy && n < 40) begin @(negedge CLK); n++; end
      check("err_wait_idle", 64'(a_srdy), 64'(1));
      check("err_h35_kept", 64'(coef(a_hact, 3, 5)), 64'(NEG1234));
      check("err_rest_zero", 64'(|(a_hact & ~m35)), 64'(0));

      // Reset in the middle of a flush
      cfg_valid = 1; cfg_commit = 1; s_vin = 1;
      @(negedge CLK);
      cfg_valid = 0; cfg_commit = 0;
      repeat (3) @(negedge CLK);
      check("mid_busy", 64'(a_busy), 64'(1));
      RST = 1'b1;
      #1;
      check("mid_rst_hact", 64'(|a_hact), 64'(0));
      check("mid_rst_fvin", 64'(a_fvin), 64'(0));
      check("mid_rst_fdin", 64'(a_fdin), 64'(0));
      @(negedge CLK);
      RST = 1'b0; s_vin = 0;
      @(negedge CLK);
      check("mid_rel_srdy", 64'(a_srdy), 64'(1));
      check("mid_rel_hact", 64'(|a_hact), 64'(0));
      check("mid_rel_fvin", 64'(a_fvin), 64'(0));

      // Randomized traffic against the model
      for (int s = 0; s < N; s++)
         for (int t = 0; t <= T; t++) begin msh[s][t] = '0; mact[s][t] = '0; end
      mbusy = 0; pend = 0; e_fvin = 0; e_fdin = '0; e_err = 0;
      cfg_hold = 0; s_hold = 0; beats = 0; cyc = 0;
      while (beats < 1000 && cyc < 20000) begin
         @(negedge CLK);
         cyc++;
         check("r_fvin", 64'(a_fvin), 64'(e_fvin));
         check("r_fdin", 64'(a_fdin), 64'(e_fdin));
         check("r_err",  64'(a_err),  64'(e_err));
         check("r_srdy", 64'(a_srdy), 64'(mbusy == 0));
         check("r_crdy", 64'(a_crdy), 64'(mbusy == 0));
         check("r_busy", 64'(a_busy), 64'(mbusy != 0));
         for (int s = 0; s < N; s++)
            for (int t = 0; t <= T; t++)
               check($sformatf("r_hact_%0d_%0d", s, t), 64'(coef(a_hact, s, t)),
                     64'(mact[s][t]));

         if (!cfg_hold) begin
            cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg_commit = ($urandom_range(0, 7) == 0);
            cfg_set    = 4'($urandom_range(0, 9));
            cfg_idx    = 4'($urandom_range(0, 9));
            cfg_data   = W'($urandom);
         end
         if (!s_hold) begin
            s_vin = 1'($urandom_range(0, 1));
            s_din = W'($urandom);
         end

         rdy = (mbusy == 0);
         if (pend) begin mact = msh; pend = 0; end
         e_err = 0;
         if (rdy && s_vin) begin
            e_fvin = 1; e_fdin = s_din; beats++;
         end else if (mbusy > 1) begin
            e_fvin = 1; e_fdin = '0;
         end else begin
            e_fvin = 0;
         end
         if (rdy && cfg_valid) begin
            beats++;
            if (cfg_commit) begin
               pend  = 1;
               mbusy = int'(T) + 2;
            end else if (32'(cfg_set) < N && 32'(cfg_idx) <= T) begin
               msh[cfg_set][cfg_idx] = cfg_data;
            end else begin
               e_err = 1;
            end
         end else if (mbusy > 0) begin
            mbusy--;
         end
         cfg_hold = cfg_valid && !rdy;
         s_hold   = s_vin && !rdy;
      end
      check("rand_done", 64'(beats >= 1000), 64'(1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
